// File: rtl/matrix_result_writeback.sv
// Result-row writeback: captures ALU result rows on Done and writes each one as 4 consecutive memory words.
// Latency: Done at cycle t with the writer idle puts word 0 on MemWrite at t+1. Peak rate is 1 word/cycle.
// Backpressure: MemReady low holds the current word. Up to FIFO_DEPTH rows (in-flight row included) are held; further rows are dropped and flagged.

// Small generic synchronous FIFO; push and pop may happen in the same cycle.
module mrw_row_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_dat_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  // Storage write, pointer advance and occupancy tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign pop_dat_o = mem_q[rd_ptr_q];
  assign empty_o   = (cnt_q == '0);
  assign cnt_o     = cnt_q;

endmodule

module matrix_result_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  Clock,
  input  logic                  ClearAll_n,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] BaseAddr,
  input  logic                  Done,
  input  logic                  Error,
  input  logic [DATA_WIDTH-1:0] NewColumn1,
  input  logic [DATA_WIDTH-1:0] NewColumn2,
  input  logic [DATA_WIDTH-1:0] NewColumn3,
  input  logic [DATA_WIDTH-1:0] NewColumn4,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemData,
  input  logic                  MemReady,
  output logic                  Busy,
  output logic [2:0]            RowsWritten,
  output logic                  MatrixDone,
  output logic                  ErrorSeen,
  output logic                  Overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CAP_W = $clog2(ROWS + 1);

  // Element [0] is NewColumn1, written first.
  typedef logic [3:0][DATA_WIDTH-1:0] row_t;
  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t                state_q;
  logic                  armed_q;
  logic [CAP_W-1:0]      cap_q;
  logic [1:0]            word_q;
  row_t                  row_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_q;
  logic [2:0]            rows_q;
  logic                  mdone_q;
  logic                  err_q;
  logic                  ovf_q;

  row_t             in_row;
  row_t             fifo_head;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] occ;
  logic             arm;
  logic             accept;
  logic             last_word;
  logic             row_done;
  logic             room;
  logic             capture_try;
  logic             push_ok;
  logic             drop;
  logic             load;
  logic             fifo_push;
  logic             fifo_pop;
  row_t             load_row;

  // Error rows are stored already zeroed so the address map is kept but no bad data reaches memory.
  assign in_row = Error ? row_t'('0) : {NewColumn4, NewColumn3, NewColumn2, NewColumn1};

  assign arm       = Start && !Busy;
  assign accept    = wr_q && MemReady;
  assign last_word = (word_q == 2'd3);
  assign row_done  = accept && last_word;

  // The row being written still occupies a buffer slot until its last word is accepted.
  assign occ  = fifo_cnt + {{(CNT_W-1){1'b0}}, wr_q};
  assign room = (occ < CNT_W'(FIFO_DEPTH)) || row_done;

  assign capture_try = Done && armed_q && (cap_q < CAP_W'(ROWS));
  assign push_ok     = capture_try && room;
  assign drop        = capture_try && !room;

  // Writer picks up a new row when idle or finishing one; an empty FIFO is bypassed for t+1 latency.
  assign load      = (!wr_q || row_done) && (!fifo_empty || push_ok);
  assign fifo_pop  = load && !fifo_empty;
  assign fifo_push = push_ok && !(load && fifo_empty);
  assign load_row  = fifo_empty ? in_row : fifo_head;

  mrw_row_fifo #(
    .WIDTH (4 * DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_row_fifo (
    .clk_i      (Clock),
    .rst_ni     (ClearAll_n),
    .push_i     (fifo_push),
    .push_dat_i (in_row),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .empty_o    (fifo_empty),
    .cnt_o      (fifo_cnt)
  );

  // Arm/capture bookkeeping and the write FSM with registered memory-port outputs
  always_ff @(posedge Clock) begin
    if (!ClearAll_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
      cap_q   <= '0;
      word_q  <= 2'd0;
      row_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rows_q  <= 3'd0;
      mdone_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      mdone_q <= 1'b0;

      if (arm) begin
        armed_q <= 1'b1;
        cap_q   <= '0;
        rows_q  <= 3'd0;
        err_q   <= 1'b0;
        ovf_q   <= 1'b0;
        addr_q  <= BaseAddr;
      end

      if (push_ok) begin
        cap_q <= cap_q + 1'b1;
        if (Error) begin
          err_q <= 1'b1;
        end
      end

      if (drop) begin
        ovf_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (load) begin
            state_q <= S_WRITE;
            wr_q    <= 1'b1;
            word_q  <= 2'd0;
            row_q   <= load_row;
            data_q  <= load_row[0];
          end
        end
        S_WRITE: begin
          if (accept) begin
            // Rows are contiguous, so the address simply advances by one per accepted word.
            addr_q <= addr_q + 1'b1;
            if (!last_word) begin
              word_q <= word_q + 2'd1;
              data_q <= row_q[word_q + 2'd1];
            end else begin
              rows_q <= rows_q + 3'd1;
              if (rows_q == 3'(ROWS - 1)) begin
                mdone_q <= 1'b1;
                armed_q <= 1'b0;
              end
              if (load) begin
                word_q <= 2'd0;
                row_q  <= load_row;
                data_q <= load_row[0];
              end else begin
                state_q <= S_IDLE;
                wr_q    <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign MemWrite    = wr_q;
  assign MemAddr     = addr_q;
  assign MemData     = data_q;
  assign Busy        = armed_q || wr_q || !fifo_empty;
  assign RowsWritten = rows_q;
  assign MatrixDone  = mdone_q;
  assign ErrorSeen   = err_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_matrix_result_writeback.sv
// Bench for matrix_result_writeback: directed rows with hand-computed expected writes.
// Expected memory writes go into a queue at stimulus time; a negedge monitor pops and compares accepted writes.
// Status outputs are checked directly from the stimulus thread.

module tb_matrix_result_writeback;

  logic        Clock = 1'b0;
  logic        ClearAll_n = 1'b0;
  logic        Start = 1'b0;
  logic [15:0] BaseAddr = 16'h0;
  logic        Done = 1'b0;
  logic        Error = 1'b0;
  logic [31:0] NewColumn1 = '0;
  logic [31:0] NewColumn2 = '0;
  logic [31:0] NewColumn3 = '0;
  logic [31:0] NewColumn4 = '0;
  logic        MemReady = 1'b0;
  logic        MemWrite;
  logic [15:0] MemAddr;
  logic [31:0] MemData;
  logic        Busy;
  logic [2:0]  RowsWritten;
  logic        MatrixDone;
  logic        ErrorSeen;
  logic        Overflow;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  acc_cnt = 0;
  int  md_cnt = 0;
  int  md_target = 0;

  matrix_result_writeback dut (
    .Clock       (Clock),
    .ClearAll_n  (ClearAll_n),
    .Start       (Start),
    .BaseAddr    (BaseAddr),
    .Done        (Done),
    .Error       (Error),
    .NewColumn1  (NewColumn1),
    .NewColumn2  (NewColumn2),
    .NewColumn3  (NewColumn3),
    .NewColumn4  (NewColumn4),
    .MemWrite    (MemWrite),
    .MemAddr     (MemAddr),
    .MemData     (MemData),
    .MemReady    (MemReady),
    .Busy        (Busy),
    .RowsWritten (RowsWritten),
    .MatrixDone  (MatrixDone),
    .ErrorSeen   (ErrorSeen),
    .Overflow    (Overflow)
  );

  always #5 Clock = ~Clock;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: MatrixDone timing first, then any write accepted at the coming edge.
  always @(negedge Clock) begin
    if (ClearAll_n && MatrixDone) begin
      md_cnt++;
      chk("matrixdone_after_final_accept", 64'(acc_cnt), 64'(md_target));
    end
    if (ClearAll_n && MemWrite && MemReady) begin
      acc_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected", MemAddr, MemData);
      end else begin
        mon_e = exp_q.pop_front();
        chk("write_addr", 64'(MemAddr), 64'(mon_e.a));
        chk("write_data", 64'(MemData), 64'(mon_e.d));
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    ClearAll_n = 1'b0;
    tick();
    ClearAll_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic do_start(input logic [15:0] base);
    Start    = 1'b1;
    BaseAddr = base;
    tick();
    Start = 1'b0;
  endtask

  task automatic do_done(input bit err, input logic [31:0] c1, input logic [31:0] c2,
                         input logic [31:0] c3, input logic [31:0] c4);
    Done = 1'b1;
    Error = err;
    NewColumn1 = c1;
    NewColumn2 = c2;
    NewColumn3 = c3;
    NewColumn4 = c4;
    tick();
    Done = 1'b0;
    Error = 1'b0;
  endtask

  // One row every 4 cycles keeps a MemReady=1 stream back-to-back without filling the buffer.
  task automatic send_row(input bit err, input logic [31:0] c1, input logic [31:0] c2,
                          input logic [31:0] c3, input logic [31:0] c4);
    do_done(err, c1, c2, c3, c4);
    repeat (3) tick();
  endtask

  task automatic exp_row(input logic [15:0] base, input bit err, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3, input logic [31:0] c4);
    logic [31:0] cols [4];
    wr_t e;
    cols = '{c1, c2, c3, c4};
    for (int i = 0; i < 4; i++) begin
      e.a = base + 16'(i);
      e.d = err ? 32'h0 : cols[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain(input int budget, input bit need_idle);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || (need_idle && Busy)) && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0 || (need_idle && Busy)) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes pending, Busy=%0b after %0d cycles", exp_q.size(), Busy, budget);
    end
    repeat (3) tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("reset_memwrite", 64'(MemWrite), 64'd0);
    chk("reset_memaddr", 64'(MemAddr), 64'd0);
    chk("reset_busy", 64'(Busy), 64'd0);
    chk("reset_rows", 64'(RowsWritten), 64'd0);
    chk("reset_flags", 64'({MatrixDone, ErrorSeen, Overflow}), 64'd0);
    ClearAll_n = 1'b1;
    tick();

    // 1: full matrix of 6s at 0x10, MemReady always high
    MemReady = 1'b1;
    md_target = acc_cnt + 16;
    do_start(16'h0010);
    chk("armed_busy", 64'(Busy), 64'd1);
    for (int r = 0; r < 4; r++) exp_row(16'h0010 + 16'(4 * r), 1'b0, 6, 6, 6, 6);
    do_done(1'b0, 6, 6, 6, 6);
    chk("latency_memwrite", 64'(MemWrite), 64'd1);
    chk("latency_addr", 64'(MemAddr), 64'h10);
    repeat (3) tick();
    for (int r = 1; r < 4; r++) send_row(1'b0, 6, 6, 6, 6);
    wait_drain(60, 1'b1);
    chk("t1_matrixdone_count", 64'(md_cnt), 64'd1);
    chk("t1_rows", 64'(RowsWritten), 64'd4);
    chk("t1_busy", 64'(Busy), 64'd0);
    // Done after completion is ignored (monitor flags any write)
    send_row(1'b0, 1, 1, 1, 1);
    chk("t1_post_done_idle", 64'(MemWrite), 64'd0);

    // 2: stall 3 cycles on word 2
    do_reset();
    MemReady = 1'b1;
    do_start(16'h0030);
    exp_row(16'h0030, 1'b0, 1, 2, 3, 4);
    do_done(1'b0, 1, 2, 3, 4);
    tick();
    tick();
    MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_stall_addr", 64'(MemAddr), 64'h32);
      chk("t2_stall_data", 64'(MemData), 64'd3);
      tick();
    end
    MemReady = 1'b1;
    wait_drain(20, 1'b0);
    chk("t2_rows", 64'(RowsWritten), 64'd1);

    // 3: overflow with MemReady low, three back-to-back Done pulses
    do_reset();
    MemReady = 1'b0;
    do_start(16'h0020);
    exp_row(16'h0020, 1'b0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    exp_row(16'h0024, 1'b0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    do_done(1'b0, 32'hA1, 32'hA2, 32'hA3, 32'hA4);
    do_done(1'b0, 32'hB1, 32'hB2, 32'hB3, 32'hB4);
    chk("t3_no_overflow_yet", 64'(Overflow), 64'd0);
    do_done(1'b0, 32'hC1, 32'hC2, 32'hC3, 32'hC4);
    chk("t3_overflow", 64'(Overflow), 64'd1);
    repeat (2) tick();
    MemReady = 1'b1;
    wait_drain(40, 1'b0);
    repeat (4) tick();
    chk("t3_rows", 64'(RowsWritten), 64'd2);
    chk("t3_overflow_sticky", 64'(Overflow), 64'd1);

    // 4: error row 1 written as zeros, other rows pass through unmodified
    do_reset();
    MemReady = 1'b1;
    md_target = acc_cnt + 16;
    do_start(16'h0050);
    exp_row(16'h0050, 1'b0, 1, 2, 3, 4);
    exp_row(16'h0054, 1'b1, -32'sd4, -32'sd4, -32'sd4, -32'sd4);
    exp_row(16'h0058, 1'b0, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'h0);
    exp_row(16'h005C, 1'b0, 5, 5, 5, 5);
    send_row(1'b0, 1, 2, 3, 4);
    send_row(1'b1, -32'sd4, -32'sd4, -32'sd4, -32'sd4);
    chk("t4_errorseen", 64'(ErrorSeen), 64'd1);
    send_row(1'b0, 32'hFFFFFFF9, 32'h7FFFFFFF, 32'h80000000, 32'h0);
    send_row(1'b0, 5, 5, 5, 5);
    wait_drain(60, 1'b1);
    chk("t4_matrixdone_count", 64'(md_cnt), 64'd2);
    chk("t4_rows", 64'(RowsWritten), 64'd4);
    chk("t4_errorseen_sticky", 64'(ErrorSeen), 64'd1);

    // 5: Done before Start and in the Start cycle ignored; Start while busy ignored
    do_reset();
    MemReady = 1'b1;
    send_row(1'b0, 7, 7, 7, 7);
    chk("t5_no_start_write", 64'(MemWrite), 64'd0);
    chk("t5_no_start_busy", 64'(Busy), 64'd0);
    Start = 1'b1;
    BaseAddr = 16'h0060;
    do_done(1'b0, 8, 8, 8, 8);
    Start = 1'b0;
    repeat (2) tick();
    chk("t5_same_cycle_write", 64'(MemWrite), 64'd0);
    chk("t5_armed", 64'(Busy), 64'd1);
    do_start(16'h0070);
    exp_row(16'h0060, 1'b0, 9, 8, 7, 6);
    send_row(1'b0, 9, 8, 7, 6);
    wait_drain(30, 1'b0);
    chk("t5_rows", 64'(RowsWritten), 64'd1);

    // 6: reset while word 1 of row 2 is on the port
    do_reset();
    MemReady = 1'b1;
    do_start(16'h0040);
    exp_row(16'h0040, 1'b0, 1, 1, 1, 1);
    exp_row(16'h0044, 1'b0, 2, 2, 2, 2);
    exp_row(16'h0048, 1'b0, 3, 3, 3, 3);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    send_row(1'b0, 1, 1, 1, 1);
    send_row(1'b0, 2, 2, 2, 2);
    do_done(1'b0, 3, 3, 3, 3);
    tick();
    chk("t6_pre_reset_addr", 64'(MemAddr), 64'h49);
    ClearAll_n = 1'b0;
    tick();
    chk("t6_reset_memwrite", 64'(MemWrite), 64'd0);
    chk("t6_reset_addr_data", 64'({MemAddr, MemData}), 64'd0);
    chk("t6_reset_status", 64'({Busy, RowsWritten, MatrixDone, ErrorSeen, Overflow}), 64'd0);
    chk("t6_words_before_reset", 64'(exp_q.size()), 64'd0);
    ClearAll_n = 1'b1;
    exp_q.delete();
    tick();
    do_start(16'h0080);
    exp_row(16'h0080, 1'b0, 4, 3, 2, 1);
    send_row(1'b0, 4, 3, 2, 1);
    wait_drain(30, 1'b0);
    chk("t6_restart_rows", 64'(RowsWritten), 64'd1);

    // 7: address wraps past 0xFFFF
    do_reset();
    MemReady = 1'b1;
    do_start(16'hFFFE);
    exp_row(16'hFFFE, 1'b0, 11, 12, 13, 14);
    send_row(1'b0, 11, 12, 13, 14);
    wait_drain(30, 1'b0);
    chk("t7_rows", 64'(RowsWritten), 64'd1);

    chk("total_matrixdone", 64'(md_cnt), 64'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
